// File: rtl/acumulador_flags_8bits.sv
// Accumulator sequencing stage around an external 8-bit signed adder.
// Accepts LOAD/ADD/SUB/CLEAR commands and returns acc plus Z/N/P/V flags.
module acumulador_flags_8bits #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [WIDTH-1:0]   in_data,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    input  logic [WIDTH-1:0]   add_s,
    input  logic               add_z,
    input  logic               add_n,
    input  logic               add_p,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   acc,
    output logic               z,
    output logic               n,
    output logic               p,
    output logic               v,
    output logic [COUNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [WIDTH-1:0]   ONE_D = WIDTH'(1);
    localparam logic [COUNT_W-1:0] ONE_C = COUNT_W'(1);

    state_t           state;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] d_r;
    logic             v_next;

    // Adder operands from the latched command; SUB feeds the two's complement of d_r
    always_comb begin
        add_a = '0;
        add_b = '0;
        unique case (op_r)
            OP_LOAD: begin
                add_b = d_r;
            end
            OP_ADD: begin
                add_a = acc;
                add_b = d_r;
            end
            OP_SUB: begin
                add_a = acc;
                add_b = (~d_r) + ONE_D;
            end
            OP_CLEAR: begin
                add_a = '0;
                add_b = '0;
            end
            default: begin
                add_a = '0;
                add_b = '0;
            end
        endcase
    end

    // Signed overflow judged against the raw operand so SUB of the most negative value is exact
    always_comb begin
        v_next = 1'b0;
        unique case (op_r)
            OP_ADD: v_next = (add_a[WIDTH-1] == d_r[WIDTH-1])
                           & (add_s[WIDTH-1] != add_a[WIDTH-1]);
            OP_SUB: v_next = (add_a[WIDTH-1] != d_r[WIDTH-1])
                           & (add_s[WIDTH-1] != add_a[WIDTH-1]);
            default: v_next = 1'b0;
        endcase
    end

    // Command FSM with registered handshake outputs and result capture
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            op_r      <= OP_LOAD;
            d_r       <= '0;
            acc       <= '0;
            z         <= 1'b1;
            n         <= 1'b0;
            p         <= 1'b1;
            v         <= 1'b0;
            op_count  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_r     <= in_op;
                        d_r      <= in_data;
                        in_ready <= 1'b0;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    acc       <= add_s;
                    z         <= add_z;
                    n         <= add_n;
                    p         <= add_p;
                    v         <= v_next;
                    op_count  <= op_count + ONE_C;
                    out_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acumulador_flags_8bits.sv
// Self-checking bench for acumulador_flags_8bits.
// Supplies the combinational adder and compares against a behavioural model.
module tb_acumulador_flags_8bits;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] in_op = 2'b00;
    logic [7:0] in_data = 8'h00;
    logic [7:0] add_a, add_b, add_s;
    logic       add_z, add_n, add_p;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] acc;
    logic       z, n, p, v;
    logic [7:0] op_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    logic [7:0] exp_acc;
    logic       exp_z, exp_n, exp_p, exp_v;
    logic [7:0] exp_count;
    logic       exp_out_valid, exp_in_ready;

    always #5 clock = ~clock;

    // External adder the block is meant to drive
    assign add_s = add_a + add_b;
    assign add_z = (add_s == 8'h00);
    assign add_n = add_s[7];
    assign add_p = ~add_s[0];

    acumulador_flags_8bits #(.WIDTH(8), .COUNT_W(8)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_data(in_data),
        .add_a(add_a), .add_b(add_b), .add_s(add_s),
        .add_z(add_z), .add_n(add_n), .add_p(add_p),
        .out_valid(out_valid), .out_ready(out_ready),
        .acc(acc), .z(z), .n(n), .p(p), .v(v),
        .op_count(op_count)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        exp_acc       = 8'h00;
        exp_z         = 1'b1;
        exp_n         = 1'b0;
        exp_p         = 1'b1;
        exp_v         = 1'b0;
        exp_count     = 8'h00;
        exp_out_valid = 1'b0;
        exp_in_ready  = 1'b1;
    endtask

    // Plain signed integer arithmetic; overflow means result outside -128..127
    task automatic model_exec(input logic [1:0] op, input logic [7:0] d);
        int a, b, full;
        logic [7:0] res;
        a = int'($signed(exp_acc));
        b = int'($signed(d));
        case (op)
            2'b00:   full = b;
            2'b01:   full = a + b;
            2'b10:   full = a - b;
            default: full = 0;
        endcase
        res = full[7:0];
        exp_v = (op == 2'b01 || op == 2'b10) && (full > 127 || full < -128);
        exp_acc   = res;
        exp_z     = (res == 8'h00);
        exp_n     = res[7];
        exp_p     = ~res[0];
        exp_count = exp_count + 8'd1;
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clock) begin
        if (chk_en && !reset) begin
            check("in_ready", in_ready, exp_in_ready);
            check("out_valid", out_valid, exp_out_valid);
            check("acc", acc, exp_acc);
            check("z", z, exp_z);
            check("n", n, exp_n);
            check("p", p, exp_p);
            check("v", v, exp_v);
            check("op_count", op_count, exp_count);
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [7:0] d,
                          input int hold, input bit poke);
        int waited = 0;
        while (!in_ready && waited < 10) begin
            @(posedge clock);
            #1 waited++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready %0b, expected 1", in_ready);
        end else begin
            in_valid = 1'b1;
            in_op    = op;
            in_data  = d;
            @(posedge clock);
            #1;
            in_valid     = 1'b0;
            in_op        = 2'b01;
            in_data      = 8'h01;
            exp_in_ready = 1'b0;
            @(posedge clock);
            #1;
            model_exec(op, d);
            exp_out_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clock);
                #1 if (poke) in_valid = ~in_valid;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clock);
            #1;
            out_ready     = 1'b0;
            exp_out_valid = 1'b0;
            exp_in_ready  = 1'b1;
        end
    endtask

    initial begin
        model_reset();
        #12 reset = 1'b0;
        chk_en = 1'b1;

        // 1: asynchronous reset in the middle of a cycle while a result is shown
        @(negedge clock);
        in_valid = 1'b1;
        in_op    = 2'b00;
        in_data  = 8'd5;
        @(posedge clock);
        #1 in_valid = 1'b0;
        exp_in_ready = 1'b0;
        @(posedge clock);
        #1 model_exec(2'b00, 8'd5);
        exp_out_valid = 1'b1;
        #2 reset = 1'b1;
        model_reset();
        #1;
        check("t1_acc", acc, 8'h00);
        check("t1_z", z, 1'b1);
        check("t1_n", n, 1'b0);
        check("t1_p", p, 1'b1);
        check("t1_v", v, 1'b0);
        check("t1_out_valid", out_valid, 1'b0);
        check("t1_op_count", op_count, 8'h00);
        @(posedge clock);
        #1 reset = 1'b0;
        #1 check("t1_in_ready", in_ready, 1'b1);

        // 2: LOAD 5, ADD 3
        do_cmd(2'b00, 8'd5, 0, 1'b0);
        do_cmd(2'b01, 8'd3, 0, 1'b0);
        check("t2_acc", acc, 8'd8);
        check("t2_zn", {z, n, p, v}, 4'b0010);
        check("t2_op_count", op_count, 8'd2);

        // 3: LOAD 100, ADD 50 overflows
        do_cmd(2'b00, 8'd100, 0, 1'b0);
        do_cmd(2'b01, 8'd50, 1, 1'b0);
        check("t3_acc", acc, 8'h96);
        check("t3_flags", {z, n, p, v}, 4'b0111);

        // 4: most negative value corner cases
        do_cmd(2'b00, 8'h80, 0, 1'b0);
        do_cmd(2'b10, 8'h80, 0, 1'b0);
        check("t4a_acc", acc, 8'h00);
        check("t4a_zv", {z, v}, 2'b10);
        do_cmd(2'b11, 8'h5a, 0, 1'b0);
        do_cmd(2'b10, 8'h80, 0, 1'b0);
        check("t4b_acc", acc, 8'h80);
        check("t4b_flags", {z, n, p, v}, 4'b0111);

        // 5: held result ignores further commands
        do_reset();
        do_cmd(2'b00, 8'd7, 3, 1'b1);
        check("t5_acc", acc, 8'd7);
        check("t5_p", p, 1'b0);
        check("t5_op_count", op_count, 8'd1);
        repeat (2) @(posedge clock);
        #1 check("t5_no_add", acc, 8'd7);

        // 6: reset during EXEC discards the operation
        @(negedge clock);
        in_valid = 1'b1;
        in_op    = 2'b01;
        in_data  = 8'd1;
        @(posedge clock);
        #1 in_valid = 1'b0;
        #1 reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("t6_acc", acc, 8'h00);
        check("t6_op_count", op_count, 8'h00);
        check("t6_out_valid", out_valid, 1'b0);
        for (int i = 0; i < 256; i++) begin
            do_cmd(2'b00, 8'(i), 0, 1'b0);
        end
        check("t6_wrap", op_count, 8'h00);
        check("t6_last_acc", acc, 8'hff);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
